// File: rtl/div_pkg.sv
// Shared widths, FSM encoding and saturation constant for the sequential divider.
package div_pkg;
  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W  = 4;
  localparam int PR_W       = 5;
  localparam int ITER_N     = 8;
  localparam int CNT_W      = 3;

  localparam logic [DIVIDEND_W-1:0] SAT_Q = 8'h7F;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    FIX,
    DONE
  } state_t;
endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bus between the controller and the divider.
interface seq_divider_if;
  import div_pkg::*;

  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  busy;
  logic                  done;
  logic                  div_zero;
  logic                  ovf;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_zero, ovf
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_zero, ovf
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor magnitude.
module div_step
  import div_pkg::*;
(
  input  logic [PR_W-1:0]      pr,
  input  logic                 din,
  input  logic [DIVISOR_W-1:0] dmag,
  output logic [PR_W-1:0]      pr_next,
  output logic                 qbit
);
  logic [PR_W-1:0] shifted;
  logic [PR_W-1:0] diff;

  // pr is always below dmag, so its top bit is zero and the 4-bit shift never loses data.
  assign shifted = {pr[PR_W-2:0], din};
  assign diff    = shifted - {1'b0, dmag};
  assign qbit    = ({pr, din} >= {2'b00, dmag});
  assign pr_next = qbit ? diff : shifted;
endmodule

// File: rtl/seq_divider.sv
// 8/4-bit restoring divider, one quotient bit per cycle; done pulses 10 cycles after start (1 on divide-by-zero).
// Signed two's-complement operation with sign fix-up and overflow detection when DIV_SIGNED_EN is defined.
module seq_divider
  import div_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave bus
);
  state_t                state;
  logic [DIVIDEND_W-1:0] a_reg;
  logic [DIVISOR_W-1:0]  b_reg;
  logic [DIVIDEND_W-1:0] q_reg;
  logic [PR_W-1:0]       pr;
  logic [DIVISOR_W-1:0]  dmag;
  logic [CNT_W-1:0]      cnt;

  logic [DIVIDEND_W-1:0] a_mag;
  logic [DIVISOR_W-1:0]  b_mag;
  logic                  neg_q;
  logic                  neg_r;
  logic                  ovf_case;
  logic [DIVIDEND_W-1:0] q_fix;
  logic [DIVISOR_W-1:0]  r_fix;
  logic [PR_W-1:0]       pr_next;
  logic                  qbit;

  div_step u_step (
    .pr      (pr),
    .din     (q_reg[DIVIDEND_W-1]),
    .dmag    (dmag),
    .pr_next (pr_next),
    .qbit    (qbit)
  );

  always_comb begin
`ifdef DIV_SIGNED_EN
    a_mag    = a_reg[DIVIDEND_W-1] ? (~a_reg + 8'd1) : a_reg;
    b_mag    = b_reg[DIVISOR_W-1]  ? (~b_reg + 4'd1) : b_reg;
    neg_q    = a_reg[DIVIDEND_W-1] ^ b_reg[DIVISOR_W-1];
    neg_r    = a_reg[DIVIDEND_W-1];
    // -128 / -1 is the only quotient that does not fit in 8 signed bits.
    ovf_case = (a_reg == 8'h80) && (b_reg == 4'hF);
`else
    a_mag    = a_reg;
    b_mag    = b_reg;
    neg_q    = 1'b0;
    neg_r    = 1'b0;
    ovf_case = 1'b0;
`endif
    q_fix = neg_q ? (~q_reg + 8'd1) : q_reg;
    r_fix = neg_r ? (~pr[DIVISOR_W-1:0] + 4'd1) : pr[DIVISOR_W-1:0];
    if (ovf_case) begin
      q_fix = SAT_Q;
      r_fix = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      q_reg         <= '0;
      pr            <= '0;
      dmag          <= '0;
      cnt           <= '0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.div_zero  <= 1'b0;
      bus.ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg    <= bus.dividend;
            b_reg    <= bus.divisor;
            bus.busy <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          pr    <= '0;
          cnt   <= '0;
          q_reg <= a_mag;
          dmag  <= b_mag;
          if (b_reg == '0) begin
            bus.quotient  <= '0;
            bus.remainder <= '0;
            bus.div_zero  <= 1'b1;
            bus.ovf       <= 1'b0;
            bus.done      <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= DONE;
          end else begin
            state <= ITER;
          end
        end
        ITER: begin
          pr    <= pr_next;
          q_reg <= {q_reg[DIVIDEND_W-2:0], qbit};
          cnt   <= cnt + 3'd1;
          if (cnt == CNT_W'(ITER_N - 1)) state <= FIX;
        end
        FIX: begin
          bus.quotient  <= q_fix;
          bus.remainder <= r_fix;
          bus.ovf       <= ovf_case;
          bus.div_zero  <= 1'b0;
          bus.done      <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= DONE;
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// Randomized scoreboard bench for seq_divider; reference results come from integer division.
module tb_seq_divider;
  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
    logic       ov;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  seq_divider_if bus ();

  seq_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [3:0] b);
    exp_t e;
    int   ia;
    int   ib;
    int   iq;
    int   ir;
`ifdef DIV_SIGNED_EN
    ia = int'($signed(a));
    ib = int'($signed(b));
`else
    ia = int'(a);
    ib = int'(b);
`endif
    e.dz  = 1'b0;
    e.ov  = 1'b0;
    e.cyc = 0;
    if (ib == 0) begin
      e.dz = 1'b1;
      e.q  = 8'h00;
      e.r  = 4'h0;
    end else if (ia == -128 && ib == -1) begin
      e.ov = 1'b1;
      e.q  = 8'h7F;
      e.r  = 4'h0;
    end else begin
      iq  = ia / ib;
      ir  = ia % ib;
      e.q = iq[7:0];
      e.r = ir[3:0];
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation, on time.
  always @(negedge clk) begin
    if (rst && bus.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", bus.quotient, e.q);
        check("remainder", bus.remainder, e.r);
        check("div_zero", bus.div_zero, e.dz);
        check("ovf", bus.ovf, e.ov);
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic run(input logic [7:0] a, input logic [3:0] b, input bit poke, input bit abort);
    exp_t e;
    int   s;
    int   k;
    bit   seen;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    e     = model(a, b);
    s     = cyc + 1;
    e.cyc = s + (e.dz ? 1 : 10);
    sb.push_back(e);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = 8'($urandom);
    bus.divisor  = 4'($urandom);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      k = cyc - s;
      if (abort && k == 5) begin
        rst = 1'b0;
        #1;
        void'(sb.pop_back());
        check("rst_quotient", bus.quotient, 0);
        check("rst_remainder", bus.remainder, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_flags", {bus.div_zero, bus.ovf}, 0);
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      if (poke && k == 4) begin
        bus.start    = 1'b1;
        bus.dividend = 8'($urandom);
        bus.divisor  = 4'($urandom_range(15, 1));
      end else begin
        bus.start = 1'b0;
      end
      if (!e.dz && k >= 1 && k <= 9) check("busy_high", bus.busy, 1);
      if (bus.done) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) check("done_timeout", 0, 1);
    check("busy_low_in_done", bus.busy, 0);
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    cyc          = 0;
    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(negedge clk);
    check("reset_quotient", bus.quotient, 0);
    check("reset_remainder", bus.remainder, 0);
    check("reset_busy_done", {bus.busy, bus.done}, 0);
    check("reset_flags", {bus.div_zero, bus.ovf}, 0);
    rst = 1'b1;

`ifdef DIV_SIGNED_EN
    run(8'd100, 4'd7, 1'b0, 1'b0);
    run(8'h9C, 4'd7, 1'b0, 1'b0);
    run(8'd100, 4'hD, 1'b0, 1'b0);
    run(8'h80, 4'hF, 1'b0, 1'b0);
    run(8'h80, 4'h1, 1'b0, 1'b0);
    run(8'h80, 4'h8, 1'b0, 1'b0);
`else
    run(8'd100, 4'd7, 1'b0, 1'b0);
    run(8'd200, 4'd13, 1'b0, 1'b0);
    run(8'd255, 4'd1, 1'b0, 1'b0);
    run(8'd255, 4'd15, 1'b0, 1'b0);
    run(8'd0, 4'd9, 1'b0, 1'b0);
`endif
    run(8'd55, 4'd0, 1'b0, 1'b0);
    run(8'd55, 4'd5, 1'b0, 1'b0);
    run(8'd77, 4'd6, 1'b1, 1'b0);
    run(8'd50, 4'd7, 1'b0, 1'b1);
    run(8'd20, 4'd3, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      run(8'($urandom), 4'($urandom), n[2] & n[0], 1'b0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
